router_out_drain: RTL and testbench

Output-port consumer that sits downstream of one router FIFO/synchronizer port (one instance per `vld_out_x`/`data_out_x`/`read_enb_x` triple). It drains the FIFO while honouring sink backpressure and parses each packet: header {len[5:0], addr[1:0]}, len payload bytes, one parity byte. It streams the payload, checks address, length and parity, and warns before the synchronizer's read-timeout soft reset fires.

---
 rtl/router_out_drain_if.sv | 32 +++
 rtl/router_out_drain.sv | 127 ++++++++++++
 tb/tb_router_out_drain.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/router_out_drain_if.sv
// Port bundle between one router output FIFO/synchronizer port and its drain.
// The drain issues reads and publishes parsed packet events on this bundle.
interface router_out_drain_if;
  logic       vld_out;
  logic [7:0] data_out;
  logic       soft_reset;
  logic       hold;
  logic       read_enb;
  logic       pkt_start;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;
  logic       addr_err;
  logic       len_err;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       pkt_done;
  logic       parity_err;
  logic       abort;
  logic       stall_warn;

  modport master (
    input  vld_out, data_out, soft_reset, hold,
    output read_enb, pkt_start, pkt_addr, pkt_len, addr_err, len_err,
           byte_valid, byte_data, pkt_done, parity_err, abort, stall_warn
  );

  modport slave (
    output vld_out, data_out, soft_reset, hold,
    input  read_enb, pkt_start, pkt_addr, pkt_len, addr_err, len_err,
           byte_valid, byte_data, pkt_done, parity_err, abort, stall_warn
  );
endinterface

// File: rtl/router_out_drain.sv
// Drains one router output FIFO under sink backpressure, parses header/payload/parity
// and warns before the synchronizer's read timeout flushes the port.
module router_out_drain #(
  parameter logic [1:0]  PORT_ID     = 2'd0,
  parameter int unsigned STALL_LIMIT = 29
) (
  input logic                clock,
  input logic                reset,
  router_out_drain_if.master bus
);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  localparam logic [4:0] STALL_MAX  = 5'h1f;
  localparam logic [4:0] WARN_LEVEL = 5'(STALL_LIMIT);

  state_t     state;
  logic [6:0] to_issue;
  logic [6:0] to_capture;
  logic       rd_pend;
  logic [7:0] parity_acc;
  logic [4:0] stall_cnt;
  logic [4:0] stall_next;
  logic       read_enb;
  logic       stalling;

  always_comb begin
    read_enb = 1'b0;
    case (state)
      IDLE:    read_enb = bus.vld_out & ~bus.hold & ~bus.soft_reset;
      BODY:    read_enb = bus.vld_out & ~bus.hold & (to_issue != 7'd0) & ~bus.soft_reset;
      default: read_enb = 1'b0;
    endcase
    if (reset) read_enb = 1'b0;
  end

  assign bus.read_enb = read_enb;

  // A stall is data waiting that we would read if the sink allowed it.
  assign stalling = bus.vld_out & bus.hold &
                    ((state == IDLE) | ((state == BODY) & (to_issue != 7'd0)));

  always_comb begin
    stall_next = stall_cnt;
    if (read_enb || !bus.vld_out || bus.soft_reset)
      stall_next = 5'd0;
    else if (stalling && (stall_cnt != STALL_MAX))
      stall_next = stall_cnt + 5'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      to_issue       <= 7'd0;
      to_capture     <= 7'd0;
      rd_pend        <= 1'b0;
      parity_acc     <= 8'd0;
      stall_cnt      <= 5'd0;
      bus.pkt_start  <= 1'b0;
      bus.pkt_addr   <= 2'd0;
      bus.pkt_len    <= 6'd0;
      bus.addr_err   <= 1'b0;
      bus.len_err    <= 1'b0;
      bus.byte_valid <= 1'b0;
      bus.byte_data  <= 8'd0;
      bus.pkt_done   <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.abort      <= 1'b0;
      bus.stall_warn <= 1'b0;
    end else begin
      bus.pkt_start  <= 1'b0;
      bus.byte_valid <= 1'b0;
      bus.pkt_done   <= 1'b0;
      bus.abort      <= 1'b0;
      stall_cnt      <= stall_next;
      bus.stall_warn <= (stall_next >= WARN_LEVEL);
      rd_pend        <= (state == BODY) & read_enb;

      case (state)
        IDLE: begin
          if (read_enb) state <= HDR;
        end
        HDR: begin
          if (bus.soft_reset) begin
            bus.abort <= 1'b1;
            rd_pend   <= 1'b0;
            state     <= IDLE;
          end else begin
            bus.pkt_addr  <= bus.data_out[1:0];
            bus.pkt_len   <= bus.data_out[7:2];
            bus.addr_err  <= (bus.data_out[1:0] != PORT_ID);
            bus.len_err   <= (bus.data_out[7:2] == 6'd0);
            bus.pkt_start <= 1'b1;
            parity_acc    <= bus.data_out;
            to_issue      <= {1'b0, bus.data_out[7:2]} + 7'd1;
            to_capture    <= {1'b0, bus.data_out[7:2]} + 7'd1;
            state         <= BODY;
          end
        end
        BODY: begin
          // Abort takes priority over any capture landing in the same cycle.
          if (bus.soft_reset) begin
            bus.abort <= 1'b1;
            rd_pend   <= 1'b0;
            state     <= IDLE;
          end else begin
            if (read_enb) to_issue <= to_issue - 7'd1;
            if (rd_pend) begin
              to_capture <= to_capture - 7'd1;
              if (to_capture > 7'd1) begin
                bus.byte_valid <= 1'b1;
                bus.byte_data  <= bus.data_out;
                parity_acc     <= parity_acc ^ bus.data_out;
              end else begin
                bus.pkt_done   <= 1'b1;
                bus.parity_err <= (parity_acc != bus.data_out);
                state          <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_out_drain.sv
// Scoreboard bench for router_out_drain: a FIFO model feeds directed packets while a
// monitor pops expected packet events whenever the DUT reports one.
module tb_router_out_drain;

  localparam logic [3:0] EV_START = 4'd1;
  localparam logic [3:0] EV_BYTE  = 4'd2;
  localparam logic [3:0] EV_DONE  = 4'd3;
  localparam logic [3:0] EV_ABORT = 4'd4;

  logic clock;
  logic reset;
  logic starve;

  logic [7:0]  fifo[$];
  logic [15:0] sb[$];

  int n_compared;
  int n_mismatched;
  int bytes_seen;
  int cyc;
  int hdr_cyc;
  int done_cyc;
  int base;

  router_out_drain_if bus ();

  router_out_drain #(
    .PORT_ID    (2'd1),
    .STALL_LIMIT(29)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // FIFO model: data appears the cycle after the read strobe.
  initial begin
    logic re;
    bus.vld_out  = 1'b0;
    bus.data_out = 8'h00;
    forever begin
      @(posedge clock);
      re = bus.read_enb;
      #1;
      if (re && (fifo.size() != 0)) bus.data_out = fifo.pop_front();
      bus.vld_out = (fifo.size() != 0) && !starve;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic scoreEvent(input string name, input logic [15:0] actual);
    if (sb.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: got unexpected event 0x%0h, expected none (t=%0t)", name, actual, $time);
    end else begin
      checkOutput(name, 32'(actual), 32'(sb.pop_front()));
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.pkt_start)
          scoreEvent("pkt_start", {EV_START, 2'b00, bus.addr_err, bus.len_err, bus.pkt_len, bus.pkt_addr});
        if (bus.byte_valid) begin
          scoreEvent("byte", {EV_BYTE, 4'h0, bus.byte_data});
          bytes_seen++;
        end
        if (bus.pkt_done) begin
          scoreEvent("pkt_done", {EV_DONE, 11'h000, bus.parity_err});
          done_cyc = cyc;
        end
        if (bus.abort)
          scoreEvent("abort", {EV_ABORT, 12'h000});
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Loads one packet into the FIFO and queues the events it should produce.
  task automatic applyStimulus(input logic [7:0] hdr, input logic [1:0] exp_addr, input logic [5:0] exp_len,
                               input logic exp_aerr, input logic exp_lerr, input int n_bytes,
                               input logic [63:0] payload, input logic [7:0] par, input logic exp_perr,
                               input int abort_after);
    int n_exp;
    fifo.push_back(hdr);
    for (int i = 0; i < n_bytes; i++) fifo.push_back(payload[8*i +: 8]);
    fifo.push_back(par);
    sb.push_back({EV_START, 2'b00, exp_aerr, exp_lerr, exp_len, exp_addr});
    n_exp = (abort_after >= 0) ? abort_after : n_bytes;
    for (int i = 0; i < n_exp; i++) sb.push_back({EV_BYTE, 4'h0, payload[8*i +: 8]});
    if (abort_after >= 0) sb.push_back({EV_ABORT, 12'h000});
    else sb.push_back({EV_DONE, 11'h000, exp_perr});
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic waitBytes(input int target);
    for (int i = 0; i < 60; i++) begin
      if (bytes_seen >= target) break;
      tick();
    end
    checkOutput("byte_wait", 32'(bytes_seen >= target), 32'd1);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    bytes_seen   = 0;
    done_cyc     = 0;
    reset        = 1'b1;
    starve       = 1'b0;
    bus.hold       = 1'b0;
    bus.soft_reset = 1'b0;

    // Reset with data waiting, then the good packet.
    applyStimulus(8'h0D, 2'd1, 6'd3, 1'b0, 1'b0, 3, 64'h332211, 8'h0D, 1'b0, -1);
    tick();
    checkOutput("rd_in_reset_1", 32'(bus.read_enb), 32'd0);
    tick();
    checkOutput("rd_in_reset_2", 32'(bus.read_enb), 32'd0);
    checkOutput("reset_outputs", 32'({bus.pkt_start, bus.pkt_addr, bus.pkt_len, bus.addr_err, bus.len_err,
                                      bus.byte_valid, bus.byte_data, bus.pkt_done, bus.parity_err,
                                      bus.abort, bus.stall_warn}), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rd_after_reset", 32'(bus.read_enb), 32'd1);
    hdr_cyc = cyc;
    waitIdle();
    checkOutput("done_latency", 32'(done_cyc - hdr_cyc), 32'd7);

    $display("[TB] bad parity and zero length");
    applyStimulus(8'h0D, 2'd1, 6'd3, 1'b0, 1'b0, 3, 64'h332211, 8'h0C, 1'b1, -1);
    waitIdle();
    base = bytes_seen;
    applyStimulus(8'h01, 2'd1, 6'd0, 1'b0, 1'b1, 0, 64'h0, 8'h01, 1'b0, -1);
    waitIdle();
    checkOutput("len0_no_bytes", 32'(bytes_seen - base), 32'd0);

    $display("[TB] wrong address");
    applyStimulus(8'h0E, 2'd2, 6'd3, 1'b1, 1'b0, 3, 64'h030201, 8'h0E, 1'b0, -1);
    waitIdle();

    $display("[TB] backpressure stall");
    bus.hold = 1'b1;
    applyStimulus(8'h0D, 2'd1, 6'd3, 1'b0, 1'b0, 3, 64'h332211, 8'h0D, 1'b0, -1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.vld_out) break;
    end
    repeat (28) tick();
    checkOutput("warn_before_limit", 32'(bus.stall_warn), 32'd0);
    checkOutput("rd_while_hold", 32'(bus.read_enb), 32'd0);
    tick();
    checkOutput("warn_at_limit", 32'(bus.stall_warn), 32'd1);
    bus.hold = 1'b0;
    #1;
    checkOutput("rd_on_release", 32'(bus.read_enb), 32'd1);
    tick();
    checkOutput("warn_cleared", 32'(bus.stall_warn), 32'd0);
    waitIdle();

    $display("[TB] hold toggling mid-payload");
    applyStimulus(8'h15, 2'd1, 6'd5, 1'b0, 1'b0, 5, 64'hE5D4C3B2A1, 8'hF4, 1'b0, -1);
    for (int i = 0; i < 14; i++) begin
      tick();
      bus.hold = ~bus.hold;
    end
    bus.hold = 1'b0;
    waitIdle();

    $display("[TB] soft reset after second payload byte");
    base = bytes_seen;
    applyStimulus(8'h15, 2'd1, 6'd5, 1'b0, 1'b0, 5, 64'hE5D4C3B2A1, 8'hF4, 1'b0, 2);
    waitBytes(base + 2);
    bus.soft_reset = 1'b1;
    fifo.delete();
    tick();
    bus.soft_reset = 1'b0;
    waitIdle();
    applyStimulus(8'h0D, 2'd1, 6'd3, 1'b0, 1'b0, 3, 64'h332211, 8'h0D, 1'b0, -1);
    waitIdle();

    $display("[TB] soft reset on parity capture");
    base = bytes_seen;
    applyStimulus(8'h09, 2'd1, 6'd2, 1'b0, 1'b0, 2, 64'hA55A, 8'hF6, 1'b0, 2);
    waitBytes(base + 2);
    bus.soft_reset = 1'b1;
    fifo.delete();
    tick();
    bus.soft_reset = 1'b0;
    waitIdle();

    $display("[TB] FIFO underflow mid-payload");
    base = bytes_seen;
    applyStimulus(8'h15, 2'd1, 6'd5, 1'b0, 1'b0, 5, 64'hE5D4C3B2A1, 8'hF4, 1'b0, -1);
    waitBytes(base + 1);
    starve = 1'b1;
    tick();
    checkOutput("rd_while_empty", 32'(bus.read_enb), 32'd0);
    repeat (3) tick();
    starve = 1'b0;
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
